// File: rtl/tx_frame_arbiter_pkg.sv
// Shared constants for the TX byte-path arbiter: source indices, FSM encoding
// and the round-robin successor helper.
package tx_frame_arbiter_pkg;

  localparam int unsigned NUM_SRC = 3;

  localparam logic [1:0] SRC_ARP  = 2'd0;
  localparam logic [1:0] SRC_ICMP = 2'd1;
  localparam logic [1:0] SRC_UDP  = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  function automatic logic [1:0] next_src(input logic [1:0] idx);
    return (idx == SRC_UDP) ? SRC_ARP : idx + 2'd1;
  endfunction

endpackage

// File: rtl/tx_frame_arbiter_if.sv
// Bundle of request, per-source byte lanes and the arbitrated output toward
// the MAC coder. The slave modport is the arbiter side.
interface tx_frame_arbiter_if;
  import tx_frame_arbiter_pkg::*;

  logic [NUM_SRC-1:0]   REQ;
  logic [NUM_SRC-1:0]   GNT;
  logic [8*NUM_SRC-1:0] IN_DATA;
  logic [NUM_SRC-1:0]   IN_VLD;
  logic [NUM_SRC-1:0]   IN_LAST;
  logic [7:0]           OUT_DATA;
  logic                 OUT_VLD;
  logic                 OUT_LAST;
  logic [1:0]           OUT_SRC;
  logic                 OUT_ABORT;
  logic                 BUSY;

  modport master (
    output REQ, IN_DATA, IN_VLD, IN_LAST,
    input  GNT, OUT_DATA, OUT_VLD, OUT_LAST, OUT_SRC, OUT_ABORT, BUSY
  );

  modport slave (
    input  REQ, IN_DATA, IN_VLD, IN_LAST,
    output GNT, OUT_DATA, OUT_VLD, OUT_LAST, OUT_SRC, OUT_ABORT, BUSY
  );

endinterface

// File: rtl/tx_frame_arbiter_rr_pick3.sv
// Combinational round-robin selector: first set request bit scanning from
// ptr_i upward, wrapping modulo 3.
module rr_pick3
  import tx_frame_arbiter_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [1:0]         ptr_i,
  output logic               vld_o,
  output logic [1:0]         idx_o
);

  logic [1:0] cand;

  always_comb begin
    vld_o = 1'b0;
    idx_o = SRC_NONE;
    cand  = ptr_i;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (!vld_o && req_i[cand]) begin
        vld_o = 1'b1;
        idx_o = cand;
      end
      cand = next_src(cand);
    end
  end

endmodule

// File: rtl/tx_frame_arbiter.sv
// Grants one of three frame sources to the MAC byte path, forwards its bytes
// with one cycle of latency, enforces the inter-frame gap and aborts stalls.
module tx_frame_arbiter
  import tx_frame_arbiter_pkg::*;
#(
  parameter int unsigned IFG_CYCLES     = 12,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input logic               CLK,
  input logic               RST,
  tx_frame_arbiter_if.slave bus
);

  localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST   = 8'(IFG_CYCLES - 1);

  arb_state_e         state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         src_q;
  logic [NUM_SRC-1:0] gnt_q;
  logic [15:0]        stall_q;
  logic [7:0]         gap_q;
  logic [7:0]         out_data_q;
  logic               out_vld_q;
  logic               out_last_q;
  logic               out_abort_q;
  logic               busy_q;

  logic               pick_vld;
  logic [1:0]         pick_idx;
  logic               sel_vld;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic               timeout;
  logic               frame_end;

  rr_pick3 u_pick (
    .req_i (bus.REQ),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_data = '0;
    case (src_q)
      SRC_ARP:  begin sel_vld = bus.IN_VLD[0]; sel_last = bus.IN_LAST[0]; sel_data = bus.IN_DATA[7:0];   end
      SRC_ICMP: begin sel_vld = bus.IN_VLD[1]; sel_last = bus.IN_LAST[1]; sel_data = bus.IN_DATA[15:8];  end
      SRC_UDP:  begin sel_vld = bus.IN_VLD[2]; sel_last = bus.IN_LAST[2]; sel_data = bus.IN_DATA[23:16]; end
      default: ;
    endcase
  end

  // A byte on the would-be timeout cycle wins: timeout only counts empty cycles.
  assign timeout   = !sel_vld && (stall_q == STALL_LAST);
  assign frame_end = (sel_vld && sel_last) || timeout;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= SRC_ARP;
      src_q       <= SRC_NONE;
      gnt_q       <= '0;
      stall_q     <= '0;
      gap_q       <= '0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_abort_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_abort_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_XFER;
            gnt_q   <= NUM_SRC'(1) << pick_idx;
            src_q   <= pick_idx;
            stall_q <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_XFER: begin
          if (sel_vld) begin
            out_data_q <= sel_data;
            out_vld_q  <= 1'b1;
            out_last_q <= sel_last;
            stall_q    <= '0;
          end else if (!timeout) begin
            stall_q <= stall_q + 16'd1;
          end
          out_abort_q <= timeout;
          if (frame_end) begin
            state_q <= ST_GAP;
            gnt_q   <= '0;
            src_q   <= SRC_NONE;
            ptr_q   <= next_src(src_q);
            stall_q <= '0;
            gap_q   <= '0;
          end
        end
        ST_GAP: begin
          if (gap_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            gap_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.GNT       = gnt_q;
  assign bus.OUT_DATA  = out_data_q;
  assign bus.OUT_VLD   = out_vld_q;
  assign bus.OUT_LAST  = out_last_q;
  assign bus.OUT_SRC   = src_q;
  assign bus.OUT_ABORT = out_abort_q;
  assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Randomized scoreboard bench for tx_frame_arbiter: the driver predicts grant,
// byte, frame-end, abort and idle events; a negedge monitor checks them.
module tb_tx_frame_arbiter;
  import tx_frame_arbiter_pkg::*;

  localparam int IFG = 12;
  localparam int TMO = 16;

  logic CLK = 1'b0;
  logic RST;

  tx_frame_arbiter_if bus();

  tx_frame_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct { logic [7:0] d; logic last; logic [1:0] src; } byte_t;
  typedef struct { int at; int src; } gnt_t;

  byte_t exp_q[$];
  gnt_t  gnt_q[$];
  int    fall_q[$];
  int    idle_q[$];
  int    abort_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int         ptr_m  = 0;
  int         free_m = 0;
  logic [2:0] req_m  = '0;
  int         since[3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s at edge %0d: got %0h want %0h", name, cyc, act, want);
    end
  endtask

  // ---------------- monitor ----------------
  logic [2:0] prev_gnt  = '0;
  logic       prev_busy = 1'b0;

  always @(negedge CLK) begin
    byte_t eb;
    gnt_t  eg;
    int    ev;
    if (!RST) begin
      prev_gnt  <= '0;
      prev_busy <= 1'b0;
    end else begin
      if (bus.OUT_VLD) begin
        chk("byte expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          chk("OUT_DATA", bus.OUT_DATA, eb.d);
          chk("OUT_LAST", bus.OUT_LAST, eb.last);
          chk("OUT_SRC", bus.OUT_SRC, eb.src);
        end
      end
      if (prev_gnt == 3'b000 && bus.GNT != 3'b000) begin
        chk("grant expected", 32'(gnt_q.size() > 0), 1);
        if (gnt_q.size() > 0) begin
          eg = gnt_q.pop_front();
          chk("GNT value", bus.GNT, 32'(1) << eg.src);
          chk("GNT edge", cyc, eg.at);
          chk("BUSY at grant", bus.BUSY, 1);
          chk("OUT_SRC at grant", bus.OUT_SRC, eg.src);
        end
      end
      if (prev_gnt != 3'b000 && bus.GNT == 3'b000) begin
        chk("grant drop expected", 32'(fall_q.size() > 0), 1);
        if (fall_q.size() > 0) begin
          ev = fall_q.pop_front();
          chk("GNT drop edge", cyc, ev);
          chk("OUT_SRC after drop", bus.OUT_SRC, SRC_NONE);
        end
      end
      if (prev_busy && !bus.BUSY) begin
        chk("idle expected", 32'(idle_q.size() > 0), 1);
        if (idle_q.size() > 0) begin
          ev = idle_q.pop_front();
          chk("BUSY fall edge", cyc, ev);
        end
      end
      if (bus.OUT_ABORT) begin
        chk("abort expected", 32'(abort_q.size() > 0), 1);
        if (abort_q.size() > 0) begin
          ev = abort_q.pop_front();
          chk("OUT_ABORT edge", cyc, ev);
          chk("OUT_LAST on abort", bus.OUT_LAST, 0);
        end
      end
      prev_gnt  <= bus.GNT;
      prev_busy <= bus.BUSY;
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Lane `act` gets the given values; every other lane gets random noise.
  task automatic drive(input int act, input logic v, input logic [7:0] d, input logic l);
    logic [2:0]  vv;
    logic [2:0]  ll;
    logic [23:0] dd;
    for (int i = 0; i < 3; i++) begin
      if (i == act) begin
        vv[i] = v; ll[i] = l; dd[8*i +: 8] = d;
      end else begin
        vv[i] = 1'($urandom); ll[i] = 1'($urandom); dd[8*i +: 8] = 8'($urandom);
      end
    end
    bus.IN_VLD  = vv;
    bus.IN_LAST = ll;
    bus.IN_DATA = dd;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(-1, 1'b0, 8'h00, 1'b0);
      step();
    end
  endtask

  task automatic request(input logic [2:0] m);
    for (int i = 0; i < 3; i++)
      if (m[i] && !req_m[i]) begin
        req_m[i] = 1'b1;
        since[i] = cyc + 1;
      end
    bus.REQ = req_m;
  endtask

  function automatic int rr_ref(input logic [2:0] m, input int p);
    for (int k = 0; k < 3; k++)
      if (m[(p + k) % 3]) return (p + k) % 3;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    #1;
    RST = 1'b0;
    #1;
    chk("rst GNT", bus.GNT, 0);
    chk("rst OUT_DATA", bus.OUT_DATA, 0);
    chk("rst OUT_VLD", bus.OUT_VLD, 0);
    chk("rst OUT_LAST", bus.OUT_LAST, 0);
    chk("rst OUT_SRC", bus.OUT_SRC, 3);
    chk("rst OUT_ABORT", bus.OUT_ABORT, 0);
    chk("rst BUSY", bus.BUSY, 0);
    chk("rst bytes drained", exp_q.size(), 0);
    req_m   = '0;
    bus.REQ = req_m;
    idle(2);
    RST    = 1'b1;
    ptr_m  = 0;
    free_m = cyc + 1;
  endtask

  // One granted frame: abort_after>=0 stalls after that many bytes,
  // rst_at>=0 resets before that byte, long_at puts TMO-1 empty cycles before
  // that byte, rereq re-raises the source's request once its frame ends.
  task automatic frame(input int len, input int abort_after, input int rst_at,
                       input int long_at, input bit rereq);
    int ms;
    int g;
    int w;
    int nb;
    int last_act;
    int ab;
    int gap;
    logic [2:0] m;
    logic [7:0] d;
    logic       l;
    ms = 32'h7fffffff;
    for (int i = 0; i < 3; i++)
      if (req_m[i] && since[i] < ms) ms = since[i];
    g = (ms > free_m) ? ms : free_m;
    for (int i = 0; i < 3; i++) m[i] = req_m[i] && (since[i] <= g);
    w = rr_ref(m, ptr_m);
    gnt_q.push_back('{g, w});
    while (cyc < g) begin
      drive(-1, 1'b0, 8'h00, 1'b0);
      step();
    end
    req_m[w] = 1'b0;
    bus.REQ  = req_m;
    last_act = g;
    nb = (abort_after >= 0) ? abort_after : len;
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        do_reset();
        return;
      end
      gap = (i == long_at) ? TMO - 1 :
            (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      repeat (gap) begin
        drive(w, 1'b0, 8'($urandom), 1'($urandom));
        step();
      end
      l = (abort_after < 0) && (i == len - 1);
      if (w == 2 && i == 0) begin
        bus.IN_VLD  = 3'b111;
        bus.IN_LAST = {l, 2'b11};
        bus.IN_DATA = 24'hC3B2A1;
        d = 8'hC3;
      end else begin
        d = 8'($urandom);
        drive(w, 1'b1, d, l);
      end
      exp_q.push_back('{d, l, l ? 2'd3 : 2'(w)});
      step();
      last_act = cyc;
    end
    if (abort_after < 0) begin
      ab = last_act;
    end else begin
      ab = last_act + TMO;
      abort_q.push_back(ab);
    end
    fall_q.push_back(ab);
    idle_q.push_back(ab + IFG);
    free_m = ab + IFG + 1;
    ptr_m  = (w + 1) % 3;
    while (cyc < ab) begin
      drive(w, 1'b0, 8'($urandom), 1'($urandom));
      step();
    end
    if (rereq) request(3'(1 << w));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not complete, edge %0d", cyc);
    $fatal(1);
  end

  initial begin
    int len;
    RST         = 1'b1;
    bus.REQ     = '0;
    bus.IN_VLD  = '0;
    bus.IN_LAST = '0;
    bus.IN_DATA = '0;
    #1 RST = 1'b0;
    #1;
    chk("init GNT", bus.GNT, 0);
    chk("init OUT_VLD", bus.OUT_VLD, 0);
    chk("init OUT_LAST", bus.OUT_LAST, 0);
    chk("init OUT_SRC", bus.OUT_SRC, 3);
    chk("init OUT_ABORT", bus.OUT_ABORT, 0);
    chk("init BUSY", bus.BUSY, 0);
    chk("init OUT_DATA", bus.OUT_DATA, 0);
    idle(2);
    RST    = 1'b1;
    free_m = cyc + 1;

    request(3'b001); frame(42, -1, -1, -1, 1'b0);   // single ARP frame
    idle(5);
    request(3'b010); frame(8, -1, -1, -1, 1'b0);    // request raised during gap
    request(3'b100); frame(5, -1, -1, -1, 1'b0);

    request(3'b111);                                 // all sources contending
    frame(60, -1, -1, -1, 1'b1);
    frame(60, -1, -1, -1, 1'b1);
    frame(60, -1, -1, -1, 1'b0);
    frame(60, -1, -1, -1, 1'b0);
    frame(60, -1, -1, -1, 1'b0);

    request(3'b010); frame(20, 10, -1, 3, 1'b0);    // ICMP stalls after 10 bytes
    request(3'b101); frame(40, -1, 20, -1, 1'b0);   // UDP, reset at byte 20
    request(3'b110);
    frame(6, -1, -1, -1, 1'b0);
    frame(3, -1, -1, -1, 1'b0);

    for (int it = 0; it < 30; it++) begin
      request(3'($urandom_range(1, 7)));
      while (req_m != 3'b000) begin
        len = $urandom_range(1, 16);
        if ($urandom_range(0, 5) == 0)
          frame(len, int'($urandom_range(0, len - 1)), -1, -1, 1'b0);
        else
          frame(len, -1, -1, -1, 1'b0);
      end
      idle($urandom_range(0, 3));
    end

    idle(IFG + 5);
    chk("bytes left", exp_q.size(), 0);
    chk("grants left", gnt_q.size(), 0);
    chk("drops left", fall_q.size(), 0);
    chk("idles left", idle_q.size(), 0);
    chk("aborts left", abort_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
